acla_corrector: RTL and testbench

Multi-cycle, variable-latency exact adder built on block-speculative carries. The operands are split into BLK-bit blocks. Each block k>0 speculates its carry-in as the group-generate of block k-1, which is the same carry approximation the team's approximate block adders use. The corrector then detects mispredicted carries and repairs affected blocks one per cycle, returning the exact sum with a valid/ready handshake. It is the receiving end of the approximate-adder datapath: it turns speculative results into exact ones for consumers that cannot tolerate error.

---
 rtl/acla_corrector.sv | 160 ++++++++++++++++
 tb/tb_acla_corrector.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/acla_corrector.sv
// Exact adder built on block-speculative carries: each block guesses its carry-in
// from the group-generate of the block below, then mispredicted blocks are repaired one per cycle.

module acla_blk #(
    parameter int BLK = 8
) (
    input  logic [BLK-1:0] a_blk,
    input  logic [BLK-1:0] b_blk,
    input  logic           spec_c,
    output logic           g,
    output logic           p,
    output logic [BLK-1:0] s
);
    logic [BLK:0] raw;

    assign raw = {1'b0, a_blk} + {1'b0, b_blk};
    assign g   = raw[BLK];
    assign p   = &(a_blk ^ b_blk);
    assign s   = raw[BLK-1:0] + {{(BLK-1){1'b0}}, spec_c};
endmodule

module acla_corrector #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8,
    parameter int NBLK  = WIDTH / BLK,
    parameter int EW    = $clog2(NBLK) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [EW-1:0]    err_cnt
);
    localparam int KW = (NBLK > 2) ? $clog2(NBLK) : 1;

    typedef enum logic [2:0] {IDLE, EVAL, ROUTE, CORRECT, DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]          op_a, op_b;
    logic                      op_c;
    logic [NBLK-1:0]           g_c, p_c, spec_c;
    logic [NBLK-1:0][BLK-1:0]  ssum_c, ssum_q, ssum_nxt;
    logic [NBLK-1:0]           g_q, p_q;
    logic                      fast_q;
    logic [KW-1:0]             k_q, km1;
    logic                      tc_q;
    logic [EW-1:0]             err_q, err_nxt;
    logic                      fix, last;

    assign spec_c[0] = op_c;

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        if (i > 0) begin : g_spec
            assign spec_c[i] = g_c[i-1];
        end
        acla_blk #(.BLK(BLK)) u_blk (
            .a_blk  (op_a[i*BLK +: BLK]),
            .b_blk  (op_b[i*BLK +: BLK]),
            .spec_c (spec_c[i]),
            .g      (g_c[i]),
            .p      (p_c[i]),
            .s      (ssum_c[i])
        );
    end

    assign km1  = k_q - 1'b1;
    assign last = (k_q == KW'(NBLK - 1));
    // Speculation only ever misses a carry of 1, so a repair is always +1.
    assign fix  = (tc_q != g_q[km1]);

    always_comb begin
        ssum_nxt = ssum_q;
        err_nxt  = err_q;
        if (state == CORRECT && fix) begin
            ssum_nxt[k_q] = ssum_q[k_q] + 1'b1;
            err_nxt       = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = EVAL;
            EVAL:    state_nxt = ROUTE;
            ROUTE:   state_nxt = fast_q ? DONE : CORRECT;
            CORRECT: if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            op_c    <= 1'b0;
            ssum_q  <= '0;
            g_q     <= '0;
            p_q     <= '0;
            fast_q  <= 1'b0;
            k_q     <= '0;
            tc_q    <= 1'b0;
            err_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            err_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_a <= a;
                    op_b <= b;
                    op_c <= cin;
                end
                EVAL: begin
                    ssum_q <= ssum_c;
                    g_q    <= g_c;
                    p_q    <= p_c;
                    fast_q <= ~|p_c[NBLK-2:0];
                    k_q    <= KW'(1);
                    tc_q   <= g_c[0] | (p_c[0] & op_c);
                    err_q  <= '0;
                end
                ROUTE: if (fast_q) begin
                    // No lower propagate blocks: carry into the top block is G of the block below.
                    sum     <= ssum_q;
                    cout    <= g_q[NBLK-1] | (p_q[NBLK-1] & g_q[NBLK-2]);
                    err_cnt <= '0;
                end
                CORRECT: begin
                    ssum_q <= ssum_nxt;
                    err_q  <= err_nxt;
                    tc_q   <= g_q[k_q] | (p_q[k_q] & tc_q);
                    k_q    <= k_q + 1'b1;
                    if (last) begin
                        sum     <= ssum_nxt;
                        cout    <= g_q[NBLK-1] | (p_q[NBLK-1] & tc_q);
                        err_cnt <= err_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
endmodule

// File: tb/tb_acla_corrector.sv
// Directed bench for acla_corrector: latency, exact sum/cout, repair counts, backpressure, reset abort.

module tb_acla_corrector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        cout;
    logic [2:0]  err_cnt;

    int passed = 0;
    int total  = 0;

    acla_corrector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic [2:0]  e;
        int          lat;
    } vec_t;

    // Issues one transaction and reports latency (edges after accept) and the result.
    task automatic do_txn(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                          output int lat, output logic rdy, output logic [31:0] s,
                          output logic co, output logic [2:0] e);
        @(negedge clk);
        rdy = in_ready;
        in_valid = 1'b1; a = ta; b = tb; cin = tc;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        s = sum; co = cout; e = err_cnt;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (sum !== 32'h0) $display("FAIL reset_sum got=%h exp=0", sum); else passed++;
        total++; if ({cout, err_cnt} !== 4'h0) $display("FAIL reset_cout_err got=%b/%0d exp=0/0", cout, err_cnt); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t v[8];
        int lat;
        logic rdy, co;
        logic [31:0] s;
        logic [2:0] e;
        v[0] = '{32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 3'd0, 2};
        v[1] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 3'd2, 5};
        v[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 3'd3, 5};
        v[3] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 3'd0, 2};
        v[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 3'd2, 5};
        v[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 3'd0, 2};
        v[6] = '{32'h0000FF00, 32'h00000000, 1'b0, 32'h0000FF00, 1'b0, 3'd0, 5};
        v[7] = '{32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 3'd1, 5};
        for (int i = 0; i < 8; i++) begin
            do_txn(v[i].a, v[i].b, v[i].cin, lat, rdy, s, co, e);
            total++; if (rdy !== 1'b1) $display("FAIL vec%0d_in_ready got=%b exp=1", i, rdy); else passed++;
            total++; if (lat != v[i].lat) $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, v[i].lat); else passed++;
            total++; if (s !== v[i].s) $display("FAIL vec%0d_sum got=%h exp=%h", i, s, v[i].s); else passed++;
            total++; if (co !== v[i].co) $display("FAIL vec%0d_cout got=%b exp=%b", i, co, v[i].co); else passed++;
            total++; if (e !== v[i].e) $display("FAIL vec%0d_err_cnt got=%0d exp=%0d", i, e, v[i].e); else passed++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        in_valid = 1'b1; a = 32'h00FFFFFF; b = 32'h00000001; cin = 1'b0;
        @(posedge clk);
        #1 a = 32'hAAAAAAAA; b = 32'h55555555; cin = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        total++; if (out_valid !== 1'b1) $display("FAIL bp_timeout got=%b exp=1", out_valid); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d got=v%b/r%b exp=v1/r0", i, out_valid, in_ready); else passed++;
            total++; if (sum !== 32'h01000000 || cout !== 1'b0 || err_cnt !== 3'd2)
                $display("FAIL bp_stable%0d got=%h/%b/%0d exp=01000000/0/2", i, sum, cout, err_cnt); else passed++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release got=r%b/v%b exp=r1/v0", in_ready, out_valid); else passed++;
        total++; if (sum !== 32'h01000000) $display("FAIL bp_no_capture got=%h exp=01000000", sum); else passed++;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic rdy, co;
        logic [31:0] s;
        logic [2:0] e;
        @(negedge clk);
        in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'h0; cin = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rstmid_hs got=v%b/r%b exp=v0/r1", out_valid, in_ready); else passed++;
        total++; if (sum !== 32'h0 || err_cnt !== 3'd0 || cout !== 1'b0)
            $display("FAIL rstmid_out got=%h/%0d/%b exp=0/0/0", sum, err_cnt, cout); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(32'h12345678, 32'h11111111, 1'b0, lat, rdy, s, co, e);
        total++; if (rdy !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", rdy); else passed++;
        total++; if (s !== 32'h23456789 || co !== 1'b0)
            $display("FAIL rstmid_next got=%h/%b exp=23456789/0", s, co); else passed++;
        total++; if (lat != 2 || e !== 3'd0)
            $display("FAIL rstmid_next_lat got=%0d/%0d exp=2/0", lat, e); else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
